// File: rtl/mem_streamer.sv
// mem_streamer
//   Read-side sequencer for a small register-image memory. A start command
//   latches a base address and word count; the block then walks the memory's
//   combinational read port and presents each word on a valid/ready stream,
//   flagging the final word and accumulating a running sum of delivered words.
//
// Ports
//   clk       clock
//   reset     synchronous reset, active low
//   start     command strobe, honoured only while idle
//   base      first read address of the burst
//   len       number of words to stream (0 allowed)
//   mem_addr  read address to the memory (the internal pointer)
//   mem_data  combinational read data from the memory
//   m_data    registered stream data
//   m_valid   stream data valid
//   m_ready   downstream ready
//   m_last    final word of the burst
//   busy      high whenever not idle
//   done      one-cycle completion pulse
//   sum       sum of all words handshaken since the last accepted start
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FETCH | capture the first word from memory
// ST_SEND  | word presented; on handshake load the next one or finish
// ST_DONE  | one-cycle done pulse, then back to idle

module mem_streamer #(
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [AW-1:0]   base,
   input  logic [AW:0]     len,
   output logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_data,
   output logic [DW-1:0]   m_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            m_last,
   output logic            busy,
   output logic            done,
   output logic [DW+AW:0]  sum
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       ptr_q, ptr_d;
   logic [AW:0]         rem_q, rem_d;
   logic [DW-1:0]       m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic [DW+AW:0]      sum_q, sum_d;
   logic                fire;

   assign fire = m_valid_q && m_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         sum_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         sum_q     <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: state_d = ST_SEND;
         ST_SEND:  if (fire && rem_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath: a "load" captures the word at the current pointer, advances
   // the pointer (wrapping naturally at AW bits) and consumes one count.
   always_comb begin
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      sum_d     = sum_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               sum_d = '0;
               if (len != '0) begin
                  ptr_d = base;
                  rem_d = len;
               end
            end
         end
         ST_FETCH: begin
            m_data_d  = mem_data;
            ptr_d     = ptr_q + AW'(1);
            rem_d     = rem_q - (AW+1)'(1);
            m_valid_d = 1'b1;
         end
         ST_SEND: begin
            if (fire) begin
               sum_d = sum_q + {{(AW+1){1'b0}}, m_data_q};
               if (rem_q == '0) begin
                  m_valid_d = 1'b0;
               end else begin
                  m_data_d  = mem_data;
                  ptr_d     = ptr_q + AW'(1);
                  rem_d     = rem_q - (AW+1)'(1);
                  m_valid_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_addr = ptr_q;
      m_data   = m_data_q;
      m_valid  = m_valid_q;
      m_last   = m_valid_q && (rem_q == '0);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      sum      = sum_q;
   end

endmodule

// File: tb/tb_mem_streamer.sv
module tb_mem_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  base;
   logic [3:0]  len;
   logic [2:0]  mem_addr;
   logic [15:0] mem_data;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [19:0] sum;

   logic [15:0] mem [8];
   int vectors = 0;
   int miscompares = 0;

   assign mem_data = mem[mem_addr];

   always #5 clk = ~clk;

   mem_streamer #(.AW(3), .DW(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last),
      .busy     (busy),
      .done     (done),
      .sum      (sum)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
   endtask

   // Reference: the burst is the list mem[(b+k) mod 8], k = 0..n-1, read as
   // the memory stood at start; each word leaves on exactly one handshake.
   task automatic run_burst(input int b, input int n, input logic [15:0] pat,
                            input bit rnd, input bit inject, input bit wr,
                            input longint want_sum);
      logic [15:0] exp_q[$];
      longint      exp_sum = 0;
      int          idx = 0;
      int          cyc = 0;
      bit          r;
      bit          written = 0;
      for (int k = 0; k < n; k++) exp_q.push_back(mem[(b + k) % 8]);
      start = 1'b1;
      base  = 3'(b);
      len   = 4'(n);
      step();
      start = 1'b0;
      base  = 3'($urandom);
      len   = 4'($urandom);
      if (n == 0) begin
         chk("len0_done", done, 1);
         chk("len0_busy", busy, 1);
         chk("len0_valid", m_valid, 0);
         chk("len0_sum", sum, 0);
         step();
         chk("len0_idle_busy", busy, 0);
         chk("len0_idle_done", done, 0);
         chk("len0_idle_valid", m_valid, 0);
         return;
      end
      chk("fetch_addr", mem_addr, b % 8);
      chk("fetch_busy", busy, 1);
      chk("fetch_valid", m_valid, 0);
      chk("fetch_sum", sum, 0);
      step();
      while (idx < n && cyc < 200) begin
         chk("valid", m_valid, 1);
         chk("data", m_data, exp_q[idx]);
         chk("last", m_last, (idx == n - 1));
         chk("addr", mem_addr, (b + idx + 1) % 8);
         chk("no_done", done, 0);
         r = rnd ? ($urandom_range(0, 99) < 60) : pat[cyc % 16];
         if (inject) begin
            start = (cyc == 1);
            base  = 3'd5;
            len   = 4'd2;
         end
         if (wr && !r && !written) begin
            mem[(b + idx) % 8] = 16'hBEEF;
            written = 1;
         end
         m_ready = r;
         step();
         if (r) begin
            exp_sum += exp_q[idx];
            idx++;
         end
         cyc++;
      end
      start = 1'b0;
      if (cyc >= 200) chk("burst_timeout", cyc, 0);
      chk("done_pulse", done, 1);
      chk("done_valid", m_valid, 0);
      chk("done_last", m_last, 0);
      chk("done_sum", sum, exp_sum);
      chk("done_busy", busy, 1);
      if (want_sum >= 0) chk("burst_sum_target", exp_sum, want_sum);
      if (inject) start = 1'b1;
      m_ready = 1'($urandom);
      step();
      start = 1'b0;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sum_hold", sum, exp_sum);
      step();
      chk("idle_stays", busy, 0);
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      base    = '0;
      len     = '0;
      m_ready = 1'b0;
      preload();
      step();
      step();
      chk("rst_data", m_data, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_addr", mem_addr, 0);
      reset = 1'b1;
      step();

      run_burst(2, 3, 16'hFFFF, 0, 0, 0, 12);
      run_burst(6, 4, 16'hFFFF, 0, 0, 0, 18);
      run_burst(0, 10, 16'hFFFF, 0, 0, 0, 39);
      run_burst(0, 4, 16'hFFB2, 0, 0, 0, 10);
      run_burst(0, 0, 16'hFFFF, 0, 0, 0, 0);
      run_burst(0, 3, 16'hFFFF, 0, 1, 0, 6);
      run_burst(0, 4, 16'hFFB2, 0, 0, 1, 10);
      preload();

      // reset in the middle of a 5-word burst, after two handshakes
      start = 1'b1; base = 3'd0; len = 4'd5; m_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("mid_data", m_data, 3);
      reset = 1'b0;
      step();
      chk("mrst_data", m_data, 0);
      chk("mrst_valid", m_valid, 0);
      chk("mrst_last", m_last, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_sum", sum, 0);
      chk("mrst_addr", mem_addr, 0);
      reset = 1'b1;
      step();
      chk("mrst_idle", busy, 0);
      run_burst(1, 2, 16'hFFFF, 0, 0, 0, 5);

      repeat (25) begin
         for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
         run_burst($urandom_range(0, 7), $urandom_range(0, 15), 16'h0000, 1, 0, 0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_streamer.md
# mem_streamer

Read-side sequencer for the 8×16 register-image memory: on a start command it walks the memory's combinational read port from a base address for a programmed number of words. It presents each word on a valid/ready output stream with a last flag and keeps a running sum of the delivered words. It sits directly downstream of the memory: it drives the memory's read address and consumes its read data.

## Interface

**Parameters**
- `AW`, default 3: memory address width; depth = 2^AW.
- `DW`, default 16: memory word width.

**Ports**
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-low.
- `start`  in  1: command strobe; sampled only in IDLE.
- `base`  in  AW: first address of the burst; latched on an accepted start.
- `len`  in  AW+1: number of words to stream (0..2^(AW+1)-1); latched on an accepted start.
- `mem_addr`  out  AW: read address to the memory; equals the internal pointer register.
- `mem_data`  in  DW: combinational read data from the memory.
- `m_data`  out  DW: stream data, registered.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: downstream ready.
- `m_last`  out  1: marks the final word of the burst; equals `m_valid` && remaining==0.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse in the DONE state.
- `sum`  out  DW+AW+1: unsigned sum of all words handshaken since the last accepted start.

## Operation

**States:** IDLE, FETCH, SEND, DONE.

**Transitions**
- **IDLE:**
  - Accepted start with `len`≠0: latch ptr=`base` and rem=`len`, clear `sum`, go to FETCH.
  - Accepted start with `len`=0: clear `sum`, go to DONE.
- **FETCH:** m_data←`mem_data`, ptr←ptr+1, rem←rem−1, m_valid←1, go to SEND.
- **SEND:**
  - While `m_valid` && !`m_ready`: hold `m_data`, `m_last`, ptr and rem unchanged.
  - On a handshake (`m_valid` && `m_ready`): `sum`←`sum`+`m_data`.
    - If rem==0: m_valid←0, go to DONE.
    - Otherwise: load the next word with the same updates as FETCH and stay in SEND.
- **DONE:** `done`=1 for one cycle, then go to IDLE.

**Rules**
- The pointer wraps modulo 2^AW. A `len` greater than 2^AW re-reads words cyclically.
- `start` in any state other than IDLE is ignored, including the DONE cycle. It is neither queued nor does it alter the latched `base`/`len`.
- `m_data` is registered, so it stays stable while valid is held even if the memory is written meanwhile.
- Words are fetched from memory only at the capture edge; later writes to an already-fetched address are not reflected.
- `sum` is zero-extended addition with no overflow possible at the declared width. It holds its value after DONE until the next accepted start.
- Synchronous reset (`reset`=0) at any point, including mid-burst, forces on the next edge:
  - state=IDLE, ptr=0, rem=0;
  - `m_data`=0, `m_valid`=0, `m_last`=0, `sum`=0, `busy`=0, `done`=0, `mem_addr`=0.
  - An in-flight word is dropped.

## Timing

- Start sampled at the edge ending cycle 0. FETCH is cycle 1, and `mem_addr`=`base` during cycle 1.
- First `m_valid` is in cycle 2.
- With `m_ready` held high: one word per cycle, N words valid in cycles 2..N+1, `m_last` in cycle N+1, `done` in cycle N+2, IDLE in cycle N+3.
- `len`=0: `done` in cycle 1, IDLE in cycle 2, `m_valid` never asserted.
- Back-pressure adds exactly one cycle per stalled cycle; there are no bubbles beyond the initial FETCH.
- `busy` rises in cycle 1 and falls in the first IDLE cycle.

## Test plan

1. **Basic burst.** Memory preloaded with mem[i]=i+1; `start`, `base`=2, `len`=3, `m_ready`=1 → `m_data` 3,4,5 in cycles 2–4, `m_last` only in cycle 4, `done` pulse in cycle 5, `sum`=12.
2. **Wrap-around.** `base`=6, `len`=4, `m_ready`=1 → `m_data` 7,8,1,2, `mem_addr` wraps 7→0, `sum`=18; `len`=10 from `base`=0 → 1..8,1,2, `sum`=39.
3. **Back-pressure.** `base`=0, `len`=4, `m_ready` pattern 0,1,0,0,1,1,0,1 → each word held stable while stalled, exactly 1,2,3,4 delivered once each, `sum`=10.
4. **Zero length and ignored start.** `len`=0 → `done` in cycle 1, no `m_valid`, `sum`=0; `start` pulsed with `base`=5 mid-burst of `base`=0, `len`=3 → stream stays 1,2,3.
5. **Reset mid-burst.** `reset`=0 after the second handshake of a `len`=5 burst → next cycle all outputs 0 and state IDLE; a new start `base`=1, `len`=2 → 2,3, `sum`=5.
6. **Memory write during stall.** Overwrite the address of the held word with 16'hBEEF while `m_ready`=0 → `m_data` unchanged until the handshake.
